// File: rtl/pdm_sample_sequencer.sv
// Sample-rate scheduler feeding the PDM modulator: sample FIFO, prime/run/underrun sequencing, muting.
// Define PDM_SOFT_MUTE_EN to replace hard muting with a ramped 9-bit gain.
module pdm_sample_sequencer #(
  parameter int unsigned SAMPLE_PERIOD = 2048,
  parameter int unsigned FIFO_DEPTH    = 8,
  parameter int unsigned PRIME_LEVEL   = 4,
  parameter int unsigned RAMP_STEP     = 16
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          enable_in,
  input  logic                          mute_in,
  input  logic [15:0]                   sample_in,
  input  logic                          sample_valid_in,
  output logic                          sample_ready_out,
  output logic signed [15:0]            level_out,
  output logic                          sample_tick_out,
  output logic                          pdm_rst_out,
  output logic                          underrun_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_out
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(SAMPLE_PERIOD);
  localparam int unsigned GW = 9;
  localparam int unsigned PW = 25;

  localparam logic [AW:0]             DEPTH_C    = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]             PRIME_C    = (AW+1)'(PRIME_LEVEL);
  localparam logic [CW-1:0]           PERIOD_END = CW'(SAMPLE_PERIOD - 1);
  localparam logic [GW-1:0]           GAIN_UNITY = GW'(256);
  localparam logic signed [PW-1:0]    LVL_MAX    = PW'(32767);
  localparam logic signed [PW-1:0]    LVL_MIN    = -PW'(32768);

  if ((SAMPLE_PERIOD < 4) || (FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) ||
      (PRIME_LEVEL < 1) || (PRIME_LEVEL > FIFO_DEPTH) || (RAMP_STEP < 1) || (RAMP_STEP > 256))
  begin : g_bad_params
    $error("pdm_sample_sequencer: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, PRIME = 2'd1, RUN = 2'd2} state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]            count_q, count_d;
  logic [15:0]            mem_q [FIFO_DEPTH];
  logic signed [15:0]     level_q, level_d;
  logic                   tick_q, tick_d, und_q, und_d, prst_q, prst_d;
  logic                   tick_c, empty_c, run_tick_c, push_c, pop_c;
  logic [GW-1:0]          gain_c;
  logic signed [15:0]     head_c, sat_c;
  logic signed [PW-1:0]   prod_c, shifted_c;

  assign tick_c           = (state_q != IDLE) && (cnt_q == PERIOD_END);
  assign empty_c          = (count_q == '0);
  assign run_tick_c       = enable_in && (state_q == RUN) && tick_c;
  assign pop_c            = run_tick_c && !empty_c;
  assign sample_ready_out = enable_in && (count_q < DEPTH_C) && (state_q != IDLE);
  assign push_c           = sample_valid_in && sample_ready_out;

  // State register
  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state; a low enable wins over any coincident tick
  always_comb begin
    state_d = state_q;
    if (!enable_in) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    state_d = PRIME;
        PRIME:   if (tick_c && (count_q >= PRIME_C)) state_d = RUN;
        RUN:     if (tick_c && empty_c) state_d = PRIME;
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef PDM_SOFT_MUTE_EN
  logic [GW-1:0] gain_q, gain_d;
  logic [GW:0]   ramp_up_c;

  // Gain ramps one step per run tick and clamps at 0 / unity
  always_comb begin
    ramp_up_c = {1'b0, gain_q} + (GW+1)'(RAMP_STEP);
    gain_d    = gain_q;
    if (state_d == IDLE) begin
      gain_d = GAIN_UNITY;
    end else if (run_tick_c) begin
      if (mute_in) gain_d = (gain_q > GW'(RAMP_STEP)) ? (gain_q - GW'(RAMP_STEP)) : '0;
      else         gain_d = (ramp_up_c >= (GW+1)'(GAIN_UNITY)) ? GAIN_UNITY : ramp_up_c[GW-1:0];
    end
    gain_c = gain_d;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) gain_q <= GAIN_UNITY;
    else        gain_q <= gain_d;
  end
`else
  assign gain_c = mute_in ? '0 : GAIN_UNITY;
`endif

  // Head sample scaled by gain (unity is exact), then saturated to 16 bits
  always_comb begin
    head_c    = $signed(mem_q[rd_ptr_q]);
    prod_c    = PW'(head_c) * $signed(PW'({1'b0, gain_c}));
    shifted_c = prod_c >>> 8;
    if (shifted_c > LVL_MAX)      sat_c = 16'sh7fff;
    else if (shifted_c < LVL_MIN) sat_c = 16'sh8000;
    else                          sat_c = shifted_c[15:0];
  end

  // Output and datapath next values
  always_comb begin
    level_d  = level_q;
    tick_d   = 1'b0;
    und_d    = run_tick_c && empty_c;
    prst_d   = (state_d != RUN);
    cnt_d    = cnt_q + CW'(1);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (state_d != RUN) begin
      level_d = '0;
    end else if (pop_c) begin
      level_d = sat_c;
      tick_d  = 1'b1;
    end
    if ((state_d != state_q) || (state_d == IDLE) || tick_c) cnt_d = '0;
    if (state_d == IDLE) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_c) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_c)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + (AW+1)'(push_c) - (AW+1)'(pop_c);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      level_q  <= '0;
      tick_q   <= 1'b0;
      und_q    <= 1'b0;
      prst_q   <= 1'b1;
    end else begin
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      level_q  <= level_d;
      tick_q   <= tick_d;
      und_q    <= und_d;
      prst_q   <= prst_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (push_c) mem_q[wr_ptr_q] <= sample_in;
  end

  assign level_out       = level_q;
  assign sample_tick_out = tick_q;
  assign underrun_out    = und_q;
  assign pdm_rst_out     = prst_q;
  assign fifo_count_out  = count_q;

endmodule

// File: tb/tb_pdm_sample_sequencer.sv
// Self-checking bench for pdm_sample_sequencer: directed table, corner sequences, random vs reference model.
module tb_pdm_sample_sequencer;

  localparam int unsigned P  = 16;
  localparam int unsigned D  = 8;
  localparam int unsigned PL = 4;
  localparam int unsigned RS = 16;

  logic               clk, rst, en, mute, valid;
  logic [15:0]        din;
  logic               ready, tick, prst, und;
  logic signed [15:0] level;
  logic [3:0]         cnt;

  pdm_sample_sequencer #(
    .SAMPLE_PERIOD(P), .FIFO_DEPTH(D), .PRIME_LEVEL(PL), .RAMP_STEP(RS)
  ) dut (
    .clk_in(clk), .rst_in(rst), .enable_in(en), .mute_in(mute),
    .sample_in(din), .sample_valid_in(valid), .sample_ready_out(ready),
    .level_out(level), .sample_tick_out(tick), .pdm_rst_out(prst),
    .underrun_out(und), .fifo_count_out(cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: mode 0=idle 1=prime 2=run, sample queue, gain as plain integer
  int m_mode, m_cnt, m_level, m_gain;
  bit m_tick, m_und, m_prst;
  int q[$];

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clamp16(int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic bit m_ready(bit e);
    return e && (q.size() < D) && (m_mode != 0);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_level = 0; m_gain = 256;
    m_tick = 0; m_und = 0; m_prst = 1;
    q.delete();
  endtask

  task automatic model_edge(bit r, bit e, bit mu, bit v, int s);
    bit rdy, tk;
    int nm, g, smp;
    if (r) begin
      model_reset();
      return;
    end
    rdy = m_ready(e);
    tk  = (m_mode != 0) && (m_cnt == P - 1);
    nm  = m_mode;
    m_tick = 0;
    m_und  = 0;
    if (!e) begin
      nm = 0; q.delete(); m_level = 0; m_gain = 256;
    end else if (m_mode == 0) begin
      nm = 1;
    end else if (m_mode == 1) begin
      if (tk && q.size() >= PL) nm = 2;
    end else if (tk) begin
`ifdef PDM_SOFT_MUTE_EN
      m_gain = mu ? ((m_gain > RS) ? m_gain - RS : 0) : ((m_gain + RS > 256) ? 256 : m_gain + RS);
      g = m_gain;
`else
      g = mu ? 0 : 256;
`endif
      if (q.size() > 0) begin
        smp = q.pop_front();
        m_level = clamp16((smp * g) >>> 8);
        m_tick = 1;
      end else begin
        m_level = 0; m_und = 1; nm = 1;
      end
    end
    if (v && rdy) q.push_back(s);
    if (nm != m_mode || nm == 0 || tk) m_cnt = 0;
    else m_cnt++;
    if (nm != 2) m_level = 0;
    m_prst = (nm != 2);
    m_mode = nm;
  endtask

  // One clock: drive at negedge, check ready, advance model at posedge, check outputs at negedge
  task automatic step(bit r, bit e, bit mu, bit v, logic [15:0] s);
    rst = r; en = e; mute = mu; valid = v; din = s;
    #1;
    chk("ready", 32'(ready), 32'(m_ready(e)));
    @(posedge clk);
    model_edge(r, e, mu, v, int'($signed(s)));
    @(negedge clk);
    chk("level", int'(level), m_level);
    chk("tick", 32'(tick), 32'(m_tick));
    chk("underrun", 32'(und), 32'(m_und));
    chk("pdm_rst", 32'(prst), 32'(m_prst));
    chk("count", 32'(cnt), q.size());
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
  endtask

  task automatic wait_tick(bit mu, bit v, logic [15:0] s);
    int k;
    k = 0;
    do begin
      step(1'b0, 1'b1, mu, v, s);
      k++;
    end while (tick !== 1'b1 && k < 3 * P);
    if (tick !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_tick: no tick within %0d cycles at %0t", 3 * P, $time);
    end
  endtask

  typedef struct {
    bit r, e, mu, v;
    int s, n;
    int lvl;
    bit tk, prs, un;
    int cn;
  } vec_t;

  vec_t tbl[$];
  int   exp_lvl, vprob;
  bit   mu_r;
  logic [15:0] rs;

  initial begin
    rst = 1'b1; en = 1'b0; mute = 1'b0; valid = 1'b0; din = '0;
    model_reset();
    @(negedge clk);

    // Prime with four samples, run them out, then underrun
    tbl.push_back(vec_t'{1, 0, 0, 0,    0,  2,    0, 0, 1, 0, 0});
    tbl.push_back(vec_t'{0, 1, 0, 0,    0,  1,    0, 0, 1, 0, 0});
    tbl.push_back(vec_t'{0, 1, 0, 1,  100,  1,    0, 0, 1, 0, 1});
    tbl.push_back(vec_t'{0, 1, 0, 1, -200,  1,    0, 0, 1, 0, 2});
    tbl.push_back(vec_t'{0, 1, 0, 1,  300,  1,    0, 0, 1, 0, 3});
    tbl.push_back(vec_t'{0, 1, 0, 1, -400,  1,    0, 0, 1, 0, 4});
    tbl.push_back(vec_t'{0, 1, 0, 0,    0, 11,    0, 0, 1, 0, 4});
    tbl.push_back(vec_t'{0, 1, 0, 0,    0,  1,    0, 0, 0, 0, 4});
    tbl.push_back(vec_t'{0, 1, 0, 0,    0, 15,    0, 0, 0, 0, 4});
    tbl.push_back(vec_t'{0, 1, 0, 0,    0,  1,  100, 1, 0, 0, 3});
    tbl.push_back(vec_t'{0, 1, 0, 0,    0, 15,  100, 0, 0, 0, 3});
    tbl.push_back(vec_t'{0, 1, 0, 0,    0,  1, -200, 1, 0, 0, 2});
    tbl.push_back(vec_t'{0, 1, 0, 0,    0, 15, -200, 0, 0, 0, 2});
    tbl.push_back(vec_t'{0, 1, 0, 0,    0,  1,  300, 1, 0, 0, 1});
    tbl.push_back(vec_t'{0, 1, 0, 0,    0, 15,  300, 0, 0, 0, 1});
    tbl.push_back(vec_t'{0, 1, 0, 0,    0,  1, -400, 1, 0, 0, 0});
    tbl.push_back(vec_t'{0, 1, 0, 0,    0, 15, -400, 0, 0, 0, 0});
    tbl.push_back(vec_t'{0, 1, 0, 0,    0,  1,    0, 0, 1, 1, 0});
    tbl.push_back(vec_t'{0, 1, 0, 0,    0,  1,    0, 0, 1, 0, 0});

    foreach (tbl[i]) begin
      for (int c = 0; c < tbl[i].n; c++)
        step(tbl[i].r, tbl[i].e, tbl[i].mu, tbl[i].v, 16'(tbl[i].s));
      chk($sformatf("tbl%0d_level", i), int'(level), tbl[i].lvl);
      chk($sformatf("tbl%0d_tick", i), 32'(tick), 32'(tbl[i].tk));
      chk($sformatf("tbl%0d_pdm_rst", i), 32'(prst), 32'(tbl[i].prs));
      chk($sformatf("tbl%0d_underrun", i), 32'(und), 32'(tbl[i].un));
      chk($sformatf("tbl%0d_count", i), 32'(cnt), tbl[i].cn);
    end

    // Fill in PRIME without a tick: ready drops at full, extra beats dropped
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b1, 16'(1000 + i));
      chk("fill_count", 32'(cnt), (i < 8) ? i + 1 : 8);
    end
    chk("fill_ready", 32'(ready), 0);
    idle(4);
    idle(1);
    for (int k = 0; k < 5; k++) begin
      wait_tick(1'b0, 1'b0, 16'd0);
      chk("drain_level", int'(level), 1000 + k);
    end

    // Push coincident with a pop at count 3
    idle(P - 1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 16'd2000);
    chk("pushpop_tick", 32'(tick), 1);
    chk("pushpop_level", int'(level), 1005);
    chk("pushpop_count", 32'(cnt), 3);
    wait_tick(1'b0, 1'b0, 16'd0);
    chk("order_level0", int'(level), 1006);
    wait_tick(1'b0, 1'b0, 16'd0);
    chk("order_level1", int'(level), 1007);
    wait_tick(1'b0, 1'b0, 16'd0);
    chk("order_level2", int'(level), 2000);

    // Enable drop on the tick cycle suppresses the tick and flushes
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 16'(7 + i));
    idle(P - 5);
    step(1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    chk("disable_tick", 32'(tick), 0);
    chk("disable_level", int'(level), 0);
    chk("disable_count", 32'(cnt), 0);
    chk("disable_pdm_rst", 32'(prst), 1);
    chk("disable_ready", 32'(ready), 0);

    // Full-scale input, muted then unmuted
    idle(1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 16'd32767);
    idle(P - 5);
    idle(1);
    chk("mute_run_pdm_rst", 32'(prst), 0);
    for (int k = 1; k <= 17; k++) begin
      wait_tick(1'b1, 1'b1, 16'd32767);
`ifdef PDM_SOFT_MUTE_EN
      exp_lvl = (32767 * ((256 - 16 * k) > 0 ? (256 - 16 * k) : 0)) >>> 8;
`else
      exp_lvl = 0;
`endif
      chk($sformatf("mute_level%0d", k), int'(level), exp_lvl);
    end
    wait_tick(1'b0, 1'b1, 16'd32767);
`ifdef PDM_SOFT_MUTE_EN
    chk("unmute_level", int'(level), 2047);
`else
    chk("unmute_level", int'(level), 32767);
`endif

    // Reset mid-run with a push in flight
    step(1'b1, 1'b1, 1'b0, 1'b1, 16'd5);
    chk("midrst_count", 32'(cnt), 0);
    chk("midrst_level", int'(level), 0);
    chk("midrst_pdm_rst", 32'(prst), 1);

    // Randomized traffic against the model, alternating over- and under-supply
    mu_r = 1'b0;
    vprob = 4;
    for (int c = 0; c < 6000; c++) begin
      if (c % 500 == 0) vprob = ((c / 500) % 2 == 1) ? 24 : 4;
      if ($urandom_range(0, 40) == 0) mu_r = ~mu_r;
      case ($urandom_range(0, 7))
        0:       rs = 16'h8000;
        1:       rs = 16'h7fff;
        default: rs = 16'($urandom);
      endcase
      step(($urandom_range(0, 999) == 0), ($urandom_range(0, 199) != 0), mu_r,
           ($urandom_range(0, vprob - 1) == 0), rs);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
